sound_arbiter: RTL and testbench

//  Sequences and shares the single speaker pin between the three sound players
//  (jump, score, game over). Takes one-cycle requests from game logic and issues
//  one-cycle start pulses to the players. Times each sound and muxes the selected

---
 rtl/sound_arbiter.sv | 262 ++++++++++++++++++++++++++
 tb/tb_sound_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sound_arbiter.sv
// -----------------------------------------------------------------------------
// sound_arbiter
//   Shares the single speaker pin between the jump, score and game-over sound
//   players. One-cycle requests from game logic are latched as sticky pending
//   bits. The highest-priority pending source (game_over > score > jump) gets a
//   one-cycle start pulse, is timed for its sound length and has its square wave
//   muxed onto audio_out_o. A silent gap separates back-to-back sounds.
//   Game over preempts a running jump or score sound and flushes the queue.
//
// Ports
//   clk            system clock
//   rst_n          synchronous active-low reset
//   enable_i       1 = sound on, 0 = audio forced low (sequencing continues)
//   req_jump_i     one-cycle request, lowest priority
//   req_score_i    one-cycle request, middle priority
//   req_over_i     one-cycle request, highest priority, preempts
//   wave_jump_i    jump player square wave
//   wave_score_i   score player square wave
//   wave_over_i    game-over player square wave
//   start_jump_o   one-cycle start pulse to the jump player
//   start_score_o  one-cycle start pulse to the score player
//   start_over_o   one-cycle start pulse to the game-over player
//   audio_out_o    registered speaker drive
//   busy_o         1 whenever the sequencer is not idle
//   active_src_o   0 none, 1 jump, 2 score, 3 over (START and PLAY only)
// -----------------------------------------------------------------------------
module sound_arbiter #(
    parameter int JUMP_LEN   = 10_000_000,
    parameter int SCORE_LEN  = 5_000_000,
    parameter int OVER_LEN   = 6_400_000,
    parameter int GAP_CYCLES = 250_000,
    parameter int CNT_W      = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable_i,
    input  logic       req_jump_i,
    input  logic       req_score_i,
    input  logic       req_over_i,
    input  logic       wave_jump_i,
    input  logic       wave_score_i,
    input  logic       wave_over_i,
    output logic       start_jump_o,
    output logic       start_score_o,
    output logic       start_over_o,
    output logic       audio_out_o,
    output logic       busy_o,
    output logic [1:0] active_src_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_PLAY  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    localparam logic [1:0] SRC_NONE  = 2'd0;
    localparam logic [1:0] SRC_JUMP  = 2'd1;
    localparam logic [1:0] SRC_SCORE = 2'd2;
    localparam logic [1:0] SRC_OVER  = 2'd3;

    localparam logic [CNT_W-1:0] TIMER_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] TIMER_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] JUMP_LOAD  = CNT_W'(JUMP_LEN - 1);
    localparam logic [CNT_W-1:0] SCORE_LOAD = CNT_W'(SCORE_LEN - 1);
    localparam logic [CNT_W-1:0] OVER_LOAD  = CNT_W'(OVER_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : TIMER_ZERO;

    // Source code -> bit position in the pending/start vectors.
    function automatic logic [2:0] src_onehot(input logic [1:0] src);
        logic [2:0] oh;
        case (src)
            SRC_JUMP:  oh = 3'b001;
            SRC_SCORE: oh = 3'b010;
            SRC_OVER:  oh = 3'b100;
            default:   oh = 3'b000;
        endcase
        return oh;
    endfunction

    // Timer preload for a source; the timer counts down to zero inclusive.
    function automatic logic [CNT_W-1:0] src_load(input logic [1:0] src);
        logic [CNT_W-1:0] ld;
        case (src)
            SRC_JUMP:  ld = JUMP_LOAD;
            SRC_SCORE: ld = SCORE_LOAD;
            SRC_OVER:  ld = OVER_LOAD;
            default:   ld = TIMER_ZERO;
        endcase
        return ld;
    endfunction

    // Fixed priority: game over, then score, then jump.
    function automatic logic [1:0] pick_winner(input logic [2:0] cand);
        logic [1:0] w;
        if (cand[2]) begin
            w = SRC_OVER;
        end else if (cand[1]) begin
            w = SRC_SCORE;
        end else if (cand[0]) begin
            w = SRC_JUMP;
        end else begin
            w = SRC_NONE;
        end
        return w;
    endfunction

    state_t           state_q, state_d;
    logic [2:0]       pend_q, pend_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [1:0]       src_q, src_d;
    logic [2:0]       start_q, start_d;
    logic             audio_q, audio_d;
    logic             busy_q, busy_d;

    logic [2:0] req_s;
    logic [2:0] cur_mask_s;
    logic [2:0] req_eff_s;
    logic [2:0] cand_s;
    logic [1:0] winner_s;
    logic       launch_s;
    logic [1:0] launch_src_s;
    logic       wave_sel_s;

    // A request for the sound already starting/playing is dropped, never queued.
    assign req_s      = {req_over_i, req_score_i, req_jump_i};
    assign cur_mask_s = ((state_q == ST_START) || (state_q == ST_PLAY)) ? src_onehot(src_q) : 3'b000;
    assign req_eff_s  = req_s & ~cur_mask_s;
    assign cand_s     = pend_q | req_eff_s;
    assign winner_s   = pick_winner(cand_s);

    // Decide whether the next edge enters START, and for which source.
    always_comb begin
        launch_s     = 1'b0;
        launch_src_s = SRC_NONE;
        case (state_q)
            ST_IDLE: begin
                launch_s     = (winner_s != SRC_NONE);
                launch_src_s = winner_s;
            end
            ST_START, ST_PLAY: begin
                // Only a fresh game-over request can interrupt; req_eff_s already
                // masks it out when game over itself is the running sound.
                launch_s     = req_eff_s[2];
                launch_src_s = SRC_OVER;
            end
            ST_GAP: begin
                launch_s     = (timer_q == TIMER_ZERO) && (winner_s != SRC_NONE);
                launch_src_s = winner_s;
            end
            default: begin
                launch_s     = 1'b0;
                launch_src_s = SRC_NONE;
            end
        endcase
    end

    // Next-state, pending, timer and source selection.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q | req_eff_s;
        timer_d = timer_q;
        src_d   = src_q;
        if (launch_s) begin
            state_d = ST_START;
            src_d   = launch_src_s;
            timer_d = src_load(launch_src_s);
            // Game over flushes every queued sound; otherwise only the winner's bit clears.
            if (launch_src_s == SRC_OVER) begin
                pend_d = 3'b000;
            end else begin
                pend_d = cand_s & ~src_onehot(launch_src_s);
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_START: begin
                    state_d = ST_PLAY;
                end
                ST_PLAY: begin
                    if (timer_q == TIMER_ZERO) begin
                        src_d = SRC_NONE;
                        if (GAP_CYCLES > 0) begin
                            state_d = ST_GAP;
                            timer_d = GAP_LOAD;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        timer_d = timer_q - TIMER_ONE;
                    end
                end
                ST_GAP: begin
                    if (timer_q == TIMER_ZERO) begin
                        state_d = ST_IDLE;
                    end else begin
                        timer_d = timer_q - TIMER_ONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    src_d   = SRC_NONE;
                    pend_d  = 3'b000;
                    timer_d = TIMER_ZERO;
                end
            endcase
        end
    end

    // Wave mux for the currently selected source.
    always_comb begin
        case (src_q)
            SRC_JUMP:  wave_sel_s = wave_jump_i;
            SRC_SCORE: wave_sel_s = wave_score_i;
            SRC_OVER:  wave_sel_s = wave_over_i;
            default:   wave_sel_s = 1'b0;
        endcase
    end

    // Output next values; start pulses coincide with the START state.
    always_comb begin
        audio_d = enable_i & (state_q == ST_PLAY) & wave_sel_s;
        busy_d  = (state_d != ST_IDLE);
        if (launch_s) begin
            start_d = src_onehot(launch_src_s);
        end else begin
            start_d = 3'b000;
        end
    end

    // Single state/output register bank with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pend_q  <= 3'b000;
            timer_q <= TIMER_ZERO;
            src_q   <= SRC_NONE;
            start_q <= 3'b000;
            audio_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            timer_q <= timer_d;
            src_q   <= src_d;
            start_q <= start_d;
            audio_q <= audio_d;
            busy_q  <= busy_d;
        end
    end

    assign start_jump_o  = start_q[0];
    assign start_score_o = start_q[1];
    assign start_over_o  = start_q[2];
    assign audio_out_o   = audio_q;
    assign busy_o        = busy_q;
    assign active_src_o  = src_q;

endmodule

// File: tb/tb_sound_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sound_arbiter
//   Directed scenarios followed by randomized traffic. The reference model
//   tracks the playing source by its start cycle and derives the phase
//   (start / play / gap / idle) from elapsed cycles and the sound lengths.
// -----------------------------------------------------------------------------
module tb_sound_arbiter;

    localparam int JUMP_LEN   = 100;
    localparam int SCORE_LEN  = 50;
    localparam int OVER_LEN   = 200;
    localparam int GAP_CYCLES = 10;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       req_jump, req_score, req_over;
    logic       wave_jump, wave_score, wave_over;
    logic       start_jump, start_score, start_over;
    logic       audio_out;
    logic       busy;
    logic [1:0] active_src;

    sound_arbiter #(
        .JUMP_LEN   (JUMP_LEN),
        .SCORE_LEN  (SCORE_LEN),
        .OVER_LEN   (OVER_LEN),
        .GAP_CYCLES (GAP_CYCLES),
        .CNT_W      (24)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable_i      (enable),
        .req_jump_i    (req_jump),
        .req_score_i   (req_score),
        .req_over_i    (req_over),
        .wave_jump_i   (wave_jump),
        .wave_score_i  (wave_score),
        .wave_over_i   (wave_over),
        .start_jump_o  (start_jump),
        .start_score_o (start_score),
        .start_over_o  (start_over),
        .audio_out_o   (audio_out),
        .busy_o        (busy),
        .active_src_o  (active_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: source being sounded (0 = none) and the cycle its START occurred.
    int       m_src = 0;
    int       m_s   = 0;
    bit [2:0] m_pend = 3'b000;
    int       cyc   = 0;
    bit       en_v  = 1'b1;

    // Observation bookkeeping for directed timing checks.
    int last_ss = -1;
    int last_sj = -1;
    int cnt_sj  = 0;
    int cnt_so  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic int len_of(input int s);
        if (s == 1) return JUMP_LEN;
        if (s == 2) return SCORE_LEN;
        if (s == 3) return OVER_LEN;
        return 0;
    endfunction

    // 0 idle, 1 start, 2 play, 3 gap -- derived from elapsed cycles since START.
    function automatic int phase_at(input int c);
        int d;
        if (m_src == 0) return 0;
        d = c - m_s;
        if (d == 0) return 1;
        if (d <= len_of(m_src)) return 2;
        if (d <= len_of(m_src) + GAP_CYCLES) return 3;
        return 0;
    endfunction

    // Drive one cycle of inputs, predict, clock, then compare.
    task automatic step(input bit rst, input bit rj, input bit rs, input bit ro);
        int       p, np, w, lw;
        bit [2:0] req, cand;
        bit       launch, wv;
        logic [2:0] e_start;
        logic       e_audio, e_busy;
        logic [1:0] e_act;

        rst_n      = rst;
        enable     = en_v;
        req_jump   = rj;
        req_score  = rs;
        req_over   = ro;
        wave_jump  = 1'($urandom_range(0, 1));
        wave_score = 1'($urandom_range(0, 1));
        wave_over  = 1'($urandom_range(0, 1));

        if (!rst) begin
            m_src   = 0;
            m_pend  = 3'b000;
            e_start = 3'b000;
            e_audio = 1'b0;
            e_busy  = 1'b0;
            e_act   = 2'd0;
        end else begin
            p = phase_at(cyc);
            if (p == 0) m_src = 0;
            req = {ro, rs, rj};
            if ((p == 1 || p == 2) && m_src != 0) req[m_src-1] = 1'b0;
            cand = m_pend | req;
            w = cand[2] ? 3 : (cand[1] ? 2 : (cand[0] ? 1 : 0));
            wv = (m_src == 1) ? wave_jump : ((m_src == 2) ? wave_score : ((m_src == 3) ? wave_over : 1'b0));
            e_audio = en_v && (p == 2) && wv;
            launch = 1'b0;
            lw = 0;
            if (p == 0 && w != 0) begin
                launch = 1'b1; lw = w;
            end else if ((p == 1 || p == 2) && req[2]) begin
                launch = 1'b1; lw = 3;
            end else if (p == 3 && (cyc - m_s) == len_of(m_src) + GAP_CYCLES && w != 0) begin
                launch = 1'b1; lw = w;
            end
            if (launch) begin
                m_src = lw;
                m_s   = cyc + 1;
                if (lw == 3) m_pend = 3'b000;
                else         m_pend = cand & ~(3'b001 << (lw - 1));
                e_start = 3'b001 << (lw - 1);
            end else begin
                m_pend  = cand;
                e_start = 3'b000;
            end
            np = phase_at(cyc + 1);
            e_busy = (np != 0);
            e_act  = (np == 1 || np == 2) ? 2'(m_src) : 2'd0;
        end

        @(posedge clk);
        #1;
        cyc++;
        check_eq("start", {29'd0, start_over, start_score, start_jump}, {29'd0, e_start});
        check_eq("audio", {31'd0, audio_out}, {31'd0, e_audio});
        check_eq("busy", {31'd0, busy}, {31'd0, e_busy});
        check_eq("active_src", {30'd0, active_src}, {30'd0, e_act});
        if (start_score) last_ss = cyc;
        if (start_jump) begin
            last_sj = cyc;
            cnt_sj++;
        end
        if (start_over) cnt_so++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b1;
        req_jump = 1'b0; req_score = 1'b0; req_over = 1'b0;
        wave_jump = 1'b0; wave_score = 1'b0; wave_over = 1'b0;
        @(negedge clk);

        // Reset state.
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        idle(3);

        // 1: single jump, full sound plus gap, then idle.
        step(1'b1, 1'b1, 1'b0, 1'b0);
        idle(120);

        // 2: simultaneous jump and score -- score first, jump LEN+GAP+1 later.
        step(1'b1, 1'b1, 1'b1, 1'b0);
        idle(220);
        check_eq("t2_spacing", 32'(last_sj - last_ss), 32'(SCORE_LEN + GAP_CYCLES + 1));

        // 3: game over 30 cycles into a jump preempts, jump never resumes.
        cnt_sj = 0; cnt_so = 0;
        step(1'b1, 1'b1, 1'b0, 1'b0);
        idle(30);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        idle(250);
        check_eq("t3_jump_starts", 32'(cnt_sj), 32'd1);
        check_eq("t3_over_starts", 32'(cnt_so), 32'd1);

        // 4: repeat jump ignored; score queued in PLAY, over in GAP flushes it.
        cnt_sj = 0;
        step(1'b1, 1'b1, 1'b0, 1'b0);
        idle(19);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        idle(19);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        idle(64);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        idle(300);
        check_eq("t4_jump_starts", 32'(cnt_sj), 32'd1);

        // 5: enable low mid-score, then reset in the middle of a jump with score queued.
        step(1'b1, 1'b0, 1'b1, 1'b0);
        idle(10);
        en_v = 1'b0;
        idle(20);
        en_v = 1'b1;
        idle(40);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        idle(20);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        idle(10);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        idle(20);

        // Randomized traffic.
        for (int i = 0; i < 20000; i++) begin
            bit r, rj, rs, ro;
            r  = ($urandom_range(0, 2999) != 0);
            rj = ($urandom_range(0, 119) == 0);
            rs = ($urandom_range(0, 149) == 0);
            ro = ($urandom_range(0, 699) == 0);
            if ($urandom_range(0, 199) == 0) en_v = ~en_v;
            step(r, rj, rs, ro);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
